// File: rtl/hls_macc_pkg.sv
// Shared constants and helpers for the hls_macc_vec dot-product MAC.
package hls_macc_pkg;

    localparam int unsigned SAT_BUS_W = 256;

    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_CALC = 3'b010;
    localparam logic [2:0] ST_DONE = 3'b100;

    // Full-precision accumulator width: product width plus lane growth plus carry-in headroom.
    function automatic int unsigned acc_w_default(input int unsigned data_w, input int unsigned lanes);
        return 2 * data_w + $clog2(lanes) + 1;
    endfunction

    // Signed saturation limits for a w-bit value, returned zero/one padded to SAT_BUS_W.
    function automatic logic [SAT_BUS_W-1:0] sat_max(input int unsigned w);
        return (SAT_BUS_W'(1) << (w - 1)) - SAT_BUS_W'(1);
    endfunction

    function automatic logic [SAT_BUS_W-1:0] sat_min(input int unsigned w);
        return {SAT_BUS_W{1'b1}} << (w - 1);
    endfunction

endpackage

// File: rtl/hls_macc_vec_lane_mul.sv
// Combinational signed DATA_W x DATA_W multiplier, result sign-extended to ACC_W.
module hls_macc_lane_mul #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 2 * DATA_W + 4
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  prod
);

    logic signed [2*DATA_W-1:0] prod_full;

    assign prod_full = a * b;
    assign prod      = ACC_W'(prod_full);

endmodule

// File: rtl/hls_macc_vec.sv
// Sequential signed dot product with ap_ctrl_hs handshake, one lane per cycle.
// Define HLS_MACC_VEC_SAT_EN to saturate each accumulate step instead of wrapping.
module hls_macc_vec
    import hls_macc_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 8,
    parameter int unsigned ACC_W  = acc_w_default(DATA_W, LANES)
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     ap_start,
    output logic                     ap_done,
    output logic                     ap_idle,
    output logic                     ap_ready,
    input  logic                     mode,
    input  logic [ACC_W-1:0]         acc_in,
    input  logic [LANES*DATA_W-1:0]  a_vec,
    input  logic [LANES*DATA_W-1:0]  b_vec,
    output logic [ACC_W-1:0]         lane_prod,
    output logic                     lane_prod_ap_vld,
    output logic [ACC_W-1:0]         ap_return,
    output logic                     ovf
);

    localparam int unsigned VEC_W = LANES * DATA_W;
    localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [2:0]               state;
    logic [2:0]               state_next;
    logic [CNT_W-1:0]         lane_cnt;
    logic [VEC_W-1:0]         a_q;
    logic [VEC_W-1:0]         b_q;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  prod;
    logic signed [ACC_W-1:0]  sum_wrap;
    logic signed [ACC_W-1:0]  sum;
    logic signed [DATA_W-1:0] a_lane;
    logic signed [DATA_W-1:0] b_lane;
    logic                     accept;
    logic                     last_lane;
    logic                     add_ovf;

    assign accept    = (state == ST_IDLE) && ap_start;
    assign last_lane = (lane_cnt == CNT_W'(LANES - 1));

    // Single shared multiplier fed from the captured operands by the lane counter.
    assign a_lane = a_q[lane_cnt*DATA_W +: DATA_W];
    assign b_lane = b_q[lane_cnt*DATA_W +: DATA_W];

    hls_macc_lane_mul #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_lane_mul (
        .a    (a_lane),
        .b    (b_lane),
        .prod (prod)
    );

    // Signed overflow: operands agree in sign but the wrapped sum does not.
    assign sum_wrap = acc + prod;
    assign add_ovf  = (acc[ACC_W-1] == prod[ACC_W-1]) && (sum_wrap[ACC_W-1] != acc[ACC_W-1]);

`ifdef HLS_MACC_VEC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

    assign sum = add_ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_wrap;
`else
    assign sum = sum_wrap;
`endif

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (ap_start) state_next = ST_CALC;
            ST_CALC: if (last_lane) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Result is loaded on the last lane so it is already valid while ap_done is high.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            lane_cnt  <= '0;
            ap_return <= '0;
            ovf       <= 1'b0;
        end else if (accept) begin
            a_q      <= a_vec;
            b_q      <= b_vec;
            acc      <= mode ? '0 : acc_in;
            lane_cnt <= '0;
            ovf      <= 1'b0;
        end else if (state == ST_CALC) begin
            acc <= sum;
            ovf <= ovf | add_ovf;
            if (last_lane) begin
                ap_return <= sum;
                lane_cnt  <= '0;
            end else begin
                lane_cnt <= lane_cnt + CNT_W'(1);
            end
        end
    end

    assign ap_done          = (state == ST_DONE);
    assign ap_ready         = ap_done;
    assign ap_idle          = (state == ST_IDLE) && !ap_start;
    assign lane_prod_ap_vld = (state == ST_CALC);
    assign lane_prod        = prod;

endmodule

// File: tb/tb_hls_macc_vec.sv
// Randomised and directed checks of hls_macc_vec against an arithmetic dot-product model.
module tb_hls_macc_vec;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned LANES   = 4;
    localparam int unsigned ACC_W   = 2 * DATA_W + $clog2(LANES) + 1;
    localparam int unsigned ACC_W16 = 16;
    localparam int unsigned VEC_W   = LANES * DATA_W;

    typedef int lanes_t [LANES];

    logic               ap_clk = 1'b0;
    logic               ap_rst;
    logic               ap_start;
    logic               mode;
    logic [ACC_W-1:0]   acc_in;
    logic [ACC_W16-1:0] acc_in16;
    logic [VEC_W-1:0]   a_vec;
    logic [VEC_W-1:0]   b_vec;

    logic               ap_done, ap_idle, ap_ready, lane_prod_ap_vld, ovf;
    logic [ACC_W-1:0]   lane_prod, ap_return;
    logic               ap_done16, ap_idle16, ap_ready16, lane_prod_ap_vld16, ovf16;
    logic [ACC_W16-1:0] lane_prod16, ap_return16;

    int n_tests   = 0;
    int n_fail    = 0;
    int done_seen = 0;

    hls_macc_vec #(.DATA_W(DATA_W), .LANES(LANES)) dut (
        .ap_clk (ap_clk), .ap_rst (ap_rst), .ap_start (ap_start),
        .ap_done (ap_done), .ap_idle (ap_idle), .ap_ready (ap_ready),
        .mode (mode), .acc_in (acc_in), .a_vec (a_vec), .b_vec (b_vec),
        .lane_prod (lane_prod), .lane_prod_ap_vld (lane_prod_ap_vld),
        .ap_return (ap_return), .ovf (ovf)
    );

    hls_macc_vec #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W16)) dut16 (
        .ap_clk (ap_clk), .ap_rst (ap_rst), .ap_start (ap_start),
        .ap_done (ap_done16), .ap_idle (ap_idle16), .ap_ready (ap_ready16),
        .mode (mode), .acc_in (acc_in16), .a_vec (a_vec), .b_vec (b_vec),
        .lane_prod (lane_prod16), .lane_prod_ap_vld (lane_prod_ap_vld16),
        .ap_return (ap_return16), .ovf (ovf16)
    );

    always #5 ap_clk = ~ap_clk;

    always @(negedge ap_clk) if (ap_done) done_seen++;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Exact integer dot product, reduced into a w-bit signed range after every step.
    function automatic void model(input bit m, input longint ain, input lanes_t a, input lanes_t b,
                                  input int w, output longint res, output bit ov);
        longint lo = -(longint'(1) << (w - 1));
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint acc_m = m ? 0 : ain;
        ov = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            longint s = acc_m + longint'(a[i]) * longint'(b[i]);
            if (s > hi || s < lo) begin
                ov = 1'b1;
`ifdef HLS_MACC_VEC_SAT_EN
                s = (s > hi) ? hi : lo;
`else
                s = (s > hi) ? s - (longint'(1) << w) : s + (longint'(1) << w);
`endif
            end
            acc_m = s;
        end
        res = acc_m;
    endfunction

    task automatic drive(input bit m, input longint ain, input lanes_t a, input lanes_t b);
        for (int i = 0; i < LANES; i++) begin
            a_vec[i*DATA_W +: DATA_W] = DATA_W'(a[i]);
            b_vec[i*DATA_W +: DATA_W] = DATA_W'(b[i]);
        end
        acc_in   = ACC_W'(ain);
        acc_in16 = ACC_W16'(ain);
        mode     = m;
    endtask

    task automatic run_one(input string tag, input bit m, input longint ain, input lanes_t a, input lanes_t b);
        longint exp_r, exp_r16;
        bit     exp_o, exp_o16;
        longint prods[$];
        int     k;
        model(m, ain, a, b, ACC_W, exp_r, exp_o);
        model(m, ain, a, b, ACC_W16, exp_r16, exp_o16);
        @(negedge ap_clk);
        drive(m, ain, a, b);
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        // Scramble inputs after accept; the run must use the captured operands.
        ap_start = 1'b0;
        a_vec    = VEC_W'($urandom);
        b_vec    = VEC_W'($urandom);
        acc_in   = ACC_W'($urandom);
        acc_in16 = ACC_W16'($urandom);
        mode     = ~m;
        k = 0;
        do begin
            @(negedge ap_clk);
            k++;
            if (lane_prod_ap_vld) prods.push_back(longint'($signed(lane_prod)));
        end while (!ap_done && k < 20);
        check({tag, "_latency"}, k, LANES + 1);
        check({tag, "_ready"}, ap_ready, 1);
        check({tag, "_ret"}, longint'($signed(ap_return)), exp_r);
        check({tag, "_ovf"}, ovf, exp_o);
        check({tag, "_ret16"}, longint'($signed(ap_return16)), exp_r16);
        check({tag, "_ovf16"}, ovf16, exp_o16);
        check({tag, "_nvld"}, prods.size(), LANES);
        for (int i = 0; i < LANES && i < prods.size(); i++)
            check({tag, "_prod"}, prods[i], longint'(a[i]) * longint'(b[i]));
    endtask

    initial begin
        lanes_t a, b, a_max;
        int     stamps[$];
        int     snap;
        longint exp_r;
        bit     exp_o;

        ap_rst   = 1'b1;
        ap_start = 1'b0;
        drive(1'b1, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0});
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
        snap = done_seen;
        repeat (5) @(posedge ap_clk);
        #1;
        check("rst_idle", ap_idle, 1);
        check("rst_ret", ap_return, 0);
        check("rst_ovf", ovf, 0);
        check("rst_vld", lane_prod_ap_vld, 0);
        check("rst_no_done", done_seen, snap);

        a = '{1, 2, 3, 4};
        b = '{5, 6, 7, 8};
        run_one("dir_m1", 1'b1, 0, a, b);
        check("dir_m1_const", longint'($signed(ap_return)), 70);
        run_one("dir_m0", 1'b0, -100, a, b);
        check("dir_m0_const", longint'($signed(ap_return)), -30);

        // Back-to-back: ap_start held high across three runs.
        model(1'b1, 0, a, b, ACC_W, exp_r, exp_o);
        @(negedge ap_clk);
        drive(1'b1, 0, a, b);
        ap_start = 1'b1;
        for (int k = 0; k < 40 && stamps.size() < 3; k++) begin
            @(negedge ap_clk);
            if (ap_done) begin
                stamps.push_back(k);
                check("b2b_ret", longint'($signed(ap_return)), exp_r);
            end
        end
        ap_start = 1'b0;
        check("b2b_count", stamps.size(), 3);
        if (stamps.size() == 3) begin
            check("b2b_period1", stamps[1] - stamps[0], LANES + 2);
            check("b2b_period2", stamps[2] - stamps[1], LANES + 2);
        end

        // Reset during lane 2 aborts the run.
        @(negedge ap_clk);
        drive(1'b1, 0, '{9, 9, 9, 9}, '{3, 3, 3, 3});
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        repeat (3) @(negedge ap_clk);
        snap = done_seen;
        ap_rst = 1'b1;
        #1;
        check("abort_ret_async", ap_return, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        repeat (8) @(posedge ap_clk);
        #1;
        check("abort_no_done", done_seen, snap);
        check("abort_idle", ap_idle, 1);
        check("abort_ret", ap_return, 0);
        check("abort_ovf", ovf, 0);
        run_one("after_abort", 1'b1, 0, a, b);

        // Overflow of the narrow accumulator instance.
        a_max = '{127, 127, 127, 127};
        run_one("ovf", 1'b1, 0, a_max, a_max);
        @(negedge ap_clk);
        check("ovf16_flag", ovf16, 1);
        check("ovf_wide_flag", ovf, 0);
`ifdef HLS_MACC_VEC_SAT_EN
        check("ovf16_raw", longint'(ap_return16), 'h7FFF);
`else
        check("ovf16_raw", longint'(ap_return16), 'hFC04);
`endif

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < LANES; i++) begin
                a[i] = int'($urandom_range(0, 255)) - 128;
                b[i] = int'($urandom_range(0, 255)) - 128;
            end
            run_one("rand", 1'($urandom), longint'($urandom_range(0, 32767)) - 16384, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hls_macc_vec.md
Name: hls_macc_vec

Overview:
- Parametrised successor to the fixed-function HLS MAC block: signed dot product of N lanes plus an optional carried-in accumulator, one lane per cycle.
- Keeps the ap_ctrl_hs handshake (ap_start/ap_done/ap_idle/ap_ready) and the ap_return result port.
- Sits in the BE datapath wherever the scalar MAC is replicated per channel.

Parameters:
- DATA_W, 32, signed lane width of a and b operands.
- LANES, 8, number of lanes N, 1..64.
- ACC_W, 2*DATA_W+$clog2(LANES)+1, accumulator and result width.

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  reset, asynchronous, active-high.
- ap_start  in  1  start request, level, sampled only in S_IDLE.
- ap_done  out  1  one-cycle pulse in S_DONE.
- ap_idle  out  1  high in S_IDLE when ap_start is low.
- ap_ready  out  1  equal to ap_done.
- mode  in  1  0: accumulate onto acc_in; 1: start from zero.
- acc_in  in  ACC_W  signed carry-in accumulator.
- a_vec  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W], signed.
- b_vec  in  LANES*DATA_W  same packing as a_vec.
- lane_prod  out  ACC_W  current lane product, sign-extended (debug tap).
- lane_prod_ap_vld  out  1  high in each S_CALC cycle.
- ap_return  out  ACC_W  final signed result, held until the next S_DONE.
- ovf  out  1  sticky overflow flag for the last run.

Behaviour:
- Reset (async assert, sync release): FSM to S_IDLE; acc, lane counter, ap_return, ovf, lane_prod cleared to 0; ap_done/ap_ready/lane_prod_ap_vld = 0.
- Operand capture: a_vec, b_vec, acc_in and mode are registered when ap_start is accepted in S_IDLE. Input changes after that have no effect.
- Before capture: acc = (mode ? 0 : acc_in); ovf cleared.
- States, one-hot:
  - S_IDLE -> S_CALC when ap_start = 1.
  - S_CALC lasts exactly LANES cycles, lane counter 0..LANES-1. Each cycle: acc += sext(a[i]*b[i]), where the product is a full 2*DATA_W signed product. On the last lane -> S_DONE.
  - S_DONE: ap_return <= acc; ap_done = ap_ready = 1 for one cycle -> S_IDLE.
- Latency: accept at cycle 0, ap_done at cycle LANES+1. With ap_start held high, the next run is accepted in the cycle after S_DONE, giving a back-to-back period of LANES+2.
- Arithmetic: two's complement, wrap modulo 2^ACC_W. ovf sets if any addition overflows signed ACC_W, and stays set until the next accept.
- LANES = 1: S_CALC is a single cycle.
- ap_rst asserted mid-run aborts the run. No ap_done is issued, and ap_return reverts to 0.
- ap_start in any state other than S_IDLE is ignored.

Optional Feature:
- Macro HLS_MACC_VEC_SAT_EN.
- Defined: each accumulate step saturates to the signed ACC_W max/min, and ovf still flags the saturation.
- Undefined: additions wrap; ovf is an informational flag only.

Decomposition:
- Package hls_macc_pkg holds:
  - State encoding constants ST_IDLE = 3'b001, ST_CALC = 3'b010, ST_DONE = 3'b100.
  - A clog2-based helper for the default ACC_W.
  - Saturation min/max helper functions.
- One sub-module, hls_macc_lane_mul: registered-free signed DATA_W x DATA_W multiplier with sign-extension to ACC_W, instantiated once and shared across lanes via the lane mux.

Test Plan:
- Reset then idle, ap_start = 0: ap_idle = 1, ap_return = 0, ap_done never pulses.
- LANES = 4, DATA_W = 8, a = {1,2,3,4}, b = {5,6,7,8}, mode = 1: ap_done at cycle 5 after accept, ap_return = 70, ovf = 0.
- Same operands, mode = 0, acc_in = -100: ap_return = -30. Four lane_prod_ap_vld pulses carrying 5, 12, 21, 32.
- ap_start held high for 3 runs: ap_done pulses exactly every 6 cycles. Changing a_vec mid-run does not alter that run's result.
- ap_rst pulsed during lane 2: no ap_done, ap_return = 0, FSM in S_IDLE; the next start yields the correct result.
- ACC_W forced to 16, a = b = {127,127,127,127}, mode = 1: ovf = 1. Result is 0xFC04 without SAT_EN, and 0x7FFF with HLS_MACC_VEC_SAT_EN.
